// File: rtl/noc_reader.sv
// -----------------------------------------------------------------------------
// noc_reader
//
// This module is the receive endpoint of a NoC router. Flits arriving on the
// router writeOut port go into a small input FIFO. The FIFO drains one flit per
// clock whenever the consumer is not stalling. For each consumed flit the block
// records the flit, counts valid flits, and raises sticky error flags when one
// of these happens:
//   - a write is dropped because the FIFO is full,
//   - a flit is addressed to another node,
//   - a per-source count sequence is broken (optional feature).
//
// Flit layout: {count[15:5], src[4:3], dest[2:1], valid[0]}
//
// Optional feature macro: NOC_READER_SEQCHECK_EN
//   When defined, the block keeps a seen bit and an 11-bit expected count for
//   each of the 4 sources, and it sets errSeq on a count mismatch.
//   When undefined, errSeq is tied to 0 and no sequence storage is built.
//
// Parameters
//   MY_ID  local node id that every consumed valid flit must be addressed to
//   DEPTH  FIFO entries, a power of 2 and at least 2
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   write        flit strobe from the router
//   dataIn       16-bit flit
//   stall        1 = hold the drain and pop nothing
//   full         registered, occupancy == DEPTH
//   almost_full  registered, occupancy >= DEPTH-1
//   pktCount     number of consumed flits with valid=1 (wraps)
//   lastData     most recently popped flit
//   lastValid    one-cycle pulse after each pop
//   errOvf       sticky, a write was dropped while full
//   errDest      sticky, a consumed valid flit had dest != MY_ID
//   errSeq       sticky, a per-source count sequence mismatch
// -----------------------------------------------------------------------------
module noc_reader #(
   parameter logic [1:0] MY_ID = 2'b11,
   parameter int          DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        write,
   input  logic [15:0] dataIn,
   input  logic        stall,
   output logic        full,
   output logic        almost_full,
   output logic [15:0] pktCount,
   output logic [15:0] lastData,
   output logic        lastValid,
   output logic        errOvf,
   output logic        errDest,
   output logic        errSeq
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
   localparam logic [CW-1:0] C_AFULL = CW'(DEPTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRAIN,
      S_PAUSED
   } state_t;

   // ---------------------------------------------------------------- storage
   logic [15:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   state_t        r_state;

   logic          r_full;
   logic          r_almost_full;
   logic [15:0]   r_pkt_count;
   logic [15:0]   r_last_data;
   logic          r_last_valid;
   logic          r_err_ovf;
   logic          r_err_dest;

   logic          w_push;
   logic          w_pop;
   logic [15:0]   w_head;
   logic [CW-1:0] w_count_next;
   state_t        w_state_next;
   logic          w_head_valid;
   logic          w_dest_bad;

   // A write is accepted only when the registered full flag is low. The FSM
   // state does not gate acceptance.
   assign w_push = write & ~r_full;

   // The state is IDLE exactly when the FIFO is empty. The state is computed
   // from the next occupancy, so after the edge it matches the occupancy.
   assign w_pop = ~stall & (r_state != S_IDLE);

   assign w_head       = r_mem[r_rd_ptr];
   assign w_head_valid = w_head[0];
   assign w_dest_bad   = (w_head[2:1] != MY_ID);

   always_comb begin
      w_count_next = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_next = r_count + 1'b1;
         2'b01:   w_count_next = r_count - 1'b1;
         default: w_count_next = r_count;   // no change, or a push and a pop together
      endcase
   end

   always_comb begin
      w_state_next = S_IDLE;
      if (w_count_next != '0)
         w_state_next = stall ? S_PAUSED : S_DRAIN;
   end

   // The FIFO data array has no reset. The pointers define which entries
   // are live, so the array can map onto distributed RAM.
   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= dataIn;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_state       <= S_IDLE;
         r_full        <= 1'b0;
         r_almost_full <= 1'b0;
         r_pkt_count   <= '0;
         r_last_data   <= '0;
         r_last_valid  <= 1'b0;
         r_err_ovf     <= 1'b0;
         r_err_dest    <= 1'b0;
      end else begin
         r_count       <= w_count_next;
         r_state       <= w_state_next;
         r_full        <= (w_count_next == C_DEPTH);
         r_almost_full <= (w_count_next >= C_AFULL);
         r_last_valid  <= w_pop;

         if (w_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;   // wraps modulo DEPTH (power of 2)

         if (write & r_full)
            r_err_ovf <= 1'b1;

         if (w_pop) begin
            r_rd_ptr    <= r_rd_ptr + 1'b1;
            r_last_data <= w_head;
            // A flit with valid=0 updates lastData and pulses lastValid.
            // It does not change pktCount or any error flag.
            if (w_head_valid) begin
               r_pkt_count <= r_pkt_count + 16'd1;
               if (w_dest_bad)
                  r_err_dest <= 1'b1;
            end
         end
      end
   end

   assign full        = r_full;
   assign almost_full = r_almost_full;
   assign pktCount    = r_pkt_count;
   assign lastData    = r_last_data;
   assign lastValid   = r_last_valid;
   assign errOvf      = r_err_ovf;
   assign errDest     = r_err_dest;

`ifdef NOC_READER_SEQCHECK_EN
   // --------------------------------------------------- per-source sequence
   logic [3:0]  r_seen;
   logic [10:0] r_expect [4];
   logic        r_err_seq;
   logic [1:0]  w_src;
   logic [10:0] w_cnt;
   logic        w_seq_upd;
   logic        w_seq_bad;

   assign w_src     = w_head[4:3];
   assign w_cnt     = w_head[15:5];
   assign w_seq_upd = w_pop & w_head_valid;
   // The first flit from a source only primes the table. A later flit must
   // carry the expected count. The 11-bit arithmetic wraps 2047 to 0.
   assign w_seq_bad = w_seq_upd & r_seen[w_src] & (w_cnt != r_expect[w_src]);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_seen    <= '0;
         r_err_seq <= 1'b0;
         for (int i = 0; i < 4; i++)
            r_expect[i] <= '0;
      end else begin
         if (w_seq_bad)
            r_err_seq <= 1'b1;
         if (w_seq_upd) begin
            // Resync to count+1 whether or not the count matched.
            r_seen[w_src]   <= 1'b1;
            r_expect[w_src] <= w_cnt + 11'd1;
         end
      end
   end

   assign errSeq = r_err_seq;
`else
   assign errSeq = 1'b0;
`endif

endmodule

// File: tb/tb_noc_reader.sv
module tb_noc_reader;

   logic        clk;
   logic        reset;
   logic        write;
   logic [15:0] dataIn;
   logic        stall;
   logic        full;
   logic        almost_full;
   logic [15:0] pktCount;
   logic [15:0] lastData;
   logic        lastValid;
   logic        errOvf;
   logic        errDest;
   logic        errSeq;

   int total = 0;
   int bad   = 0;

`ifdef NOC_READER_SEQCHECK_EN
   localparam logic SEQ = 1'b1;
`else
   localparam logic SEQ = 1'b0;
`endif

   noc_reader #(.MY_ID(2'b11), .DEPTH(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .write       (write),
      .dataIn      (dataIn),
      .stall       (stall),
      .full        (full),
      .almost_full (almost_full),
      .pktCount    (pktCount),
      .lastData    (lastData),
      .lastValid   (lastValid),
      .errOvf      (errOvf),
      .errDest     (errDest),
      .errSeq      (errSeq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One rising edge, then settle 1 time unit so registered outputs are stable.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      $display("check %-16s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      write = 1'b0;
      stall = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset  = 1'b1;
      write  = 1'b0;
      dataIn = 16'h0000;
      stall  = 1'b0;
      #2;
      tick();
      reset = 1'b0;

      // ---- reset state
      chk("rst_full",   16'(full),        16'd0);
      chk("rst_afull",  16'(almost_full), 16'd0);
      chk("rst_pkt",    pktCount,         16'd0);
      chk("rst_last",   lastData,         16'd0);
      chk("rst_lval",   16'(lastValid),   16'd0);
      chk("rst_errs",   {13'd0, errOvf, errDest, errSeq}, 16'd0);

      // ---- single flit: accept at edge N, pop at N+1
      write = 1'b1; dataIn = 16'h0017;
      tick();
      write = 1'b0;
      chk("sf_nopop_yet", 16'(lastValid), 16'd0);
      tick();
      chk("sf_data",    lastData,         16'h0017);
      chk("sf_lval",    16'(lastValid),   16'd1);
      chk("sf_pkt",     pktCount,         16'd1);
      chk("sf_errs",    {13'd0, errOvf, errDest, errSeq}, 16'd0);
      tick();
      chk("sf_lval_end", 16'(lastValid),  16'd0);
      chk("sf_hold",    lastData,         16'h0017);

      // ---- backpressure: src 3, dest 3, counts 0..4
      stall = 1'b1; write = 1'b1;
      dataIn = 16'h001F; tick();
      chk("bp_af1",     {14'd0, full, almost_full}, 16'b00);
      dataIn = 16'h003F; tick();
      chk("bp_af2",     {14'd0, full, almost_full}, 16'b00);
      dataIn = 16'h005F; tick();
      chk("bp_af3",     {14'd0, full, almost_full}, 16'b01);
      dataIn = 16'h007F; tick();
      chk("bp_full4",   {14'd0, full, almost_full}, 16'b11);
      chk("bp_noovf",   16'(errOvf),      16'd0);
      dataIn = 16'h009F; tick();
      chk("bp_ovf",     16'(errOvf),      16'd1);
      chk("bp_full5",   16'(full),        16'd1);
      write = 1'b0; stall = 1'b0;
      tick();
      chk("bp_pop1",    lastData,         16'h001F);
      chk("bp_lv1",     16'(lastValid),   16'd1);
      chk("bp_fl1",     {14'd0, full, almost_full}, 16'b01);
      tick();
      chk("bp_pop2",    lastData,         16'h003F);
      chk("bp_af_drop", 16'(almost_full), 16'd0);
      tick();
      chk("bp_pop3",    lastData,         16'h005F);
      tick();
      chk("bp_pop4",    lastData,         16'h007F);
      chk("bp_pkt",     pktCount,         16'd5);
      tick();
      chk("bp_idle",    16'(lastValid),   16'd0);
      chk("bp_ovf_stk", 16'(errOvf),      16'd1);

      // ---- simultaneous push/pop at occupancy DEPTH-1
      stall = 1'b1; write = 1'b1;
      dataIn = 16'h009F; tick();
      dataIn = 16'h00BF; tick();
      dataIn = 16'h00DF; tick();
      chk("pp_pre_af",  {14'd0, full, almost_full}, 16'b01);
      stall = 1'b0; dataIn = 16'h00FF; tick();
      chk("pp_flags",   {14'd0, full, almost_full}, 16'b01);
      chk("pp_data",    lastData,         16'h009F);
      write = 1'b0;
      tick();
      chk("pp_d2",      lastData,         16'h00BF);
      tick();
      chk("pp_d3",      lastData,         16'h00DF);
      tick();
      chk("pp_d4",      lastData,         16'h00FF);
      chk("pp_pkt",     pktCount,         16'd9);
      chk("pp_af_end",  16'(almost_full), 16'd0);

      // ---- dest check, then a valid=0 flit
      write = 1'b1; dataIn = 16'h0013; tick();
      write = 1'b0; tick();
      chk("dc_data",    lastData,         16'h0013);
      chk("dc_errdest", 16'(errDest),     16'd1);
      chk("dc_pkt",     pktCount,         16'd10);
      chk("dc_errseq",  16'(errSeq),      16'(SEQ));   // src2 count 0 again, expected 1
      write = 1'b1; dataIn = 16'h0000; tick();
      write = 1'b0; tick();
      chk("nv_data",    lastData,         16'h0000);
      chk("nv_lval",    16'(lastValid),   16'd1);
      chk("nv_pkt",     pktCount,         16'd10);

      // ---- reset mid-burst
      do_reset();
      stall = 1'b1; write = 1'b1;
      dataIn = 16'h0007; tick();
      dataIn = 16'h0027; tick();
      dataIn = 16'h0047; tick();
      write = 1'b0;
      chk("rb_pre_af",  16'(almost_full), 16'd1);
      stall = 1'b0;
      reset = 1'b1;
      #1;
      chk("rb_async",   {13'd0, full, almost_full, lastValid}, 16'd0);
      chk("rb_pkt",     pktCount,         16'd0);
      tick();
      reset = 1'b0;
      tick();
      chk("rb_nopop",   16'(lastValid),   16'd0);
      tick();
      chk("rb_nopop2",  {15'd0, lastValid} | lastData | pktCount, 16'd0);

      // ---- sequence: src 0 counts 0,1,3
      write = 1'b1; dataIn = 16'h0007; tick();
      dataIn = 16'h0027; tick();
      dataIn = 16'h0067; tick();
      write = 1'b0;
      chk("sq_ok2",     16'(errSeq),      16'd0);
      chk("sq_d2",      lastData,         16'h0027);
      tick();
      chk("sq_d3",      lastData,         16'h0067);
      chk("sq_err",     16'(errSeq),      16'(SEQ));

      // ---- sequence: src 1 counts 2047,0 wrap is legal
      do_reset();
      write = 1'b1; dataIn = 16'hFFEF; tick();
      dataIn = 16'h000F; tick();
      write = 1'b0; tick();
      chk("wr_data",    lastData,         16'h000F);
      chk("wr_pkt",     pktCount,         16'd2);
      chk("wr_noerr",   16'(errSeq),      16'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Watchdog so the run always terminates.
   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "timeout");
   end

endmodule
